// File: rtl/pci_target_burst_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : pci_target_burst_ctrl
// Brief    : PCI memory target with BAR decode, programmable wait states and
//            linear bursts that disconnect on a beat limit or at the window end.
// Revision : 1.0  initial release
// =============================================================================

module pci_target_burst_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter int                SIZE_LOG2   = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_1000,
    parameter int                WAIT_STATES = 0,
    parameter int                MAX_BURST   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_n,
    input  logic              irdy_n,
    input  logic [ADDR_W-1:0] ad_in,
    input  logic [3:0]        cbe_n,
    output logic              devsel_n,
    output logic              trdy_n,
    output logic              stop_n,
    output logic              re,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        be
);

    localparam logic [3:0] c_cmd_mem_rd = 4'b0110;
    localparam logic [3:0] c_cmd_mem_wr = 4'b0111;

    localparam int c_beat_w = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_beat_w-1:0] c_beat_last = c_beat_w'(MAX_BURST - 1);

    // Reads need at least one wait state for the AD bus turnaround.
    localparam logic [3:0] c_wait_wr = 4'(WAIT_STATES);
    localparam logic [3:0] c_wait_rd = (WAIT_STATES == 0) ? 4'd1 : 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BUSY = 3'd1,
        S_WAIT = 3'd2,
        S_DATA = 3'd3,
        S_STOP = 3'd4,
        S_TURN = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [c_beat_w-1:0] r_beat;
    logic [c_beat_w-1:0] w_beat_nxt;
    logic [3:0]          r_wait;
    logic [3:0]          w_wait_nxt;
    logic                r_dir;
    logic                w_dir_nxt;

    logic                w_cmd_wr;
    logic                w_cmd_rd;
    logic                w_hit;
    logic [3:0]          w_wait_load;
    logic                w_win_end;
    logic                w_last;
    logic                w_bus_idle;
    logic                w_xfer;
    logic                w_unused_ad;

    assign w_cmd_wr    = (cbe_n == c_cmd_mem_wr);
    assign w_cmd_rd    = (cbe_n == c_cmd_mem_rd);
    assign w_hit       = (w_cmd_wr | w_cmd_rd) &&
                         (ad_in[ADDR_W-1:SIZE_LOG2] == BASE_ADDR[ADDR_W-1:SIZE_LOG2]);
    assign w_wait_load = w_cmd_wr ? c_wait_wr : c_wait_rd;
    assign w_win_end   = &r_addr[SIZE_LOG2-1:2];
    assign w_last      = (r_beat == c_beat_last) || w_win_end;
    assign w_bus_idle  = frame_n & irdy_n;
    assign w_xfer      = (r_state == S_DATA) & ~irdy_n;
    assign w_unused_ad = ^ad_in[1:0];

    assign addr = r_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_beat  <= '0;
            r_wait  <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_beat  <= w_beat_nxt;
            r_wait  <= w_wait_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_beat_nxt  = r_beat;
        w_wait_nxt  = r_wait;
        w_dir_nxt   = r_dir;
        devsel_n    = 1'b1;
        trdy_n      = 1'b1;
        stop_n      = 1'b1;
        re          = 1'b0;
        we          = 1'b0;
        be          = 4'h0;

        case (r_state)
            S_IDLE, S_TURN: begin
                w_state_nxt = S_IDLE;
                if (!frame_n) begin
                    if (w_hit) begin
                        w_addr_nxt = {ad_in[ADDR_W-1:2], 2'b00};
                        w_dir_nxt  = w_cmd_wr;
                        w_beat_nxt = '0;
                        // The WAIT state is entered once per wait cycle; zero waits skips it.
                        if (w_wait_load == 4'd0) begin
                            w_state_nxt = S_DATA;
                        end else begin
                            w_state_nxt = S_WAIT;
                            w_wait_nxt  = w_wait_load - 4'd1;
                        end
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                if (w_bus_idle) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_WAIT: begin
                devsel_n = 1'b0;
                if (w_bus_idle) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wait == 4'd0) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end

            S_DATA: begin
                devsel_n = 1'b0;
                trdy_n   = 1'b0;
                stop_n   = ~w_last;
                be       = ~cbe_n;
                re       = w_xfer & ~r_dir;
                we       = w_xfer & r_dir;
                if (w_bus_idle) begin
                    w_state_nxt = S_IDLE;
                end else if (w_xfer) begin
                    // Holding the address at the window end keeps it inside the BAR.
                    if (!w_win_end) begin
                        w_addr_nxt = r_addr + ADDR_W'(4);
                    end
                    if (!w_last) begin
                        w_beat_nxt = r_beat + c_beat_w'(1);
                    end
                    if (frame_n) begin
                        w_state_nxt = S_TURN;
                    end else if (w_last) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end

            S_STOP: begin
                devsel_n = 1'b0;
                stop_n   = 1'b0;
                if (w_bus_idle) begin
                    w_state_nxt = S_IDLE;
                end else if (frame_n) begin
                    w_state_nxt = S_TURN;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_pci_target_burst_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_pci_target_burst_ctrl
// Brief    : Self-checking bench: vector table, directed corner cases and a
//            random PCI master scored against a transaction-level model.
// Revision : 1.0  initial release
// =============================================================================

module tb_pci_target_burst_ctrl;

    localparam int MAXB = 8;

    logic        clk;
    logic        rst_n;
    logic        frame_n;
    logic        irdy_n;
    logic [31:0] ad_in;
    logic [3:0]  cbe_n;

    logic        devsel_n0, trdy_n0, stop_n0, re0, we0;
    logic [31:0] addr0;
    logic [3:0]  be0;
    logic        devsel_n3, trdy_n3, stop_n3, re3, we3;
    logic [31:0] addr3;
    logic [3:0]  be3;

    bit          sel;
    logic        m_devsel_n, m_trdy_n, m_stop_n, m_re, m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        re;
        logic        we;
        logic [3:0]  be;
        logic        stop;
    } strobe_t;

    strobe_t obs_q[$];
    strobe_t exp_q[$];

    typedef struct {
        logic        f;
        logic        i;
        logic [31:0] ad;
        logic [3:0]  cbe;
        logic [4:0]  ctl;   // {devsel_n, trdy_n, stop_n, re, we}
        logic [31:0] adr;
        logic [3:0]  be;
    } vec_t;

    pci_target_burst_ctrl #(
        .ADDR_W(32), .SIZE_LOG2(8), .BASE_ADDR(32'h0000_1000),
        .WAIT_STATES(0), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n),
        .ad_in(ad_in), .cbe_n(cbe_n), .devsel_n(devsel_n0), .trdy_n(trdy_n0),
        .stop_n(stop_n0), .re(re0), .we(we0), .addr(addr0), .be(be0)
    );

    pci_target_burst_ctrl #(
        .ADDR_W(32), .SIZE_LOG2(8), .BASE_ADDR(32'h0000_1000),
        .WAIT_STATES(3), .MAX_BURST(MAXB)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n),
        .ad_in(ad_in), .cbe_n(cbe_n), .devsel_n(devsel_n3), .trdy_n(trdy_n3),
        .stop_n(stop_n3), .re(re3), .we(we3), .addr(addr3), .be(be3)
    );

    assign m_devsel_n = sel ? devsel_n3 : devsel_n0;
    assign m_trdy_n   = sel ? trdy_n3   : trdy_n0;
    assign m_stop_n   = sel ? stop_n3   : stop_n0;
    assign m_re       = sel ? re3       : re0;
    assign m_we       = sel ? we3       : we0;
    assign m_addr     = sel ? addr3     : addr0;
    assign m_be       = sel ? be3       : be0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && (m_re || m_we))
            obs_q.push_back('{addr: m_addr, re: m_re, we: m_we, be: m_be, stop: ~m_stop_n});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        ad_in   = '0;
        cbe_n   = 4'hF;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        obs_q.delete();
    endtask

    function automatic vec_t mk(logic f, logic i, logic [31:0] ad, logic [3:0] cbe,
                                logic [4:0] ctl, logic [31:0] adr, logic [3:0] be);
        vec_t v;
        v.f = f; v.i = i; v.ad = ad; v.cbe = cbe; v.ctl = ctl; v.adr = adr; v.be = be;
        return v;
    endfunction

    // PCI master: one transaction of n beats, one irdy wait before beat k when wmask[k].
    // Expected strobes come from window/burst arithmetic, independent of bus timing.
    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] a, input int n,
                           input int unsigned wmask);
        logic [3:0] be_arr[16];
        strobe_t    e;
        bit         hit, waited, fin, disc, abort, saw_devsel;
        int         k, room, base, beat, guard, lat, waits, cyc0, wst;

        hit = (cmd == 4'h6 || cmd == 4'h7) && (a >= 32'h1000) && (a < 32'h1100);
        for (int i = 0; i < 16; i++) be_arr[i] = 4'($urandom);
        exp_q.delete();
        obs_q.delete();
        if (hit) begin
            base = int'({a[31:2], 2'b00});
            room = (32'h1100 - base) / 4;
            k = n;
            if (k > MAXB) k = MAXB;
            if (k > room) k = room;
            for (int i = 0; i < k; i++) begin
                e.addr = 32'(base + 4 * i);
                e.re   = (cmd == 4'h6);
                e.we   = (cmd == 4'h7);
                e.be   = be_arr[i];
                e.stop = (i == MAXB - 1) || (e.addr == 32'h10FC);
                exp_q.push_back(e);
            end
        end
        wst   = sel ? 3 : 0;
        waits = (cmd == 4'h7) ? wst : ((wst == 0) ? 1 : wst);

        frame_n = 1'b0;
        irdy_n  = 1'b1;
        ad_in   = a;
        cbe_n   = cmd;
        cyc0    = cyc;
        tick();

        beat = 0; waited = 0; fin = 0; disc = 0; abort = 0;
        saw_devsel = 0; guard = 0; lat = -1;
        while (!fin) begin
            if (wmask[beat] && !waited) begin
                irdy_n = 1'b1;
                waited = 1;
            end else begin
                irdy_n = 1'b0;
            end
            if (!irdy_n && beat == n - 1) frame_n = 1'b1;
            cbe_n = ~be_arr[beat];
            ad_in = $urandom;
            @(negedge clk);
            if (!m_devsel_n) saw_devsel = 1;
            if (!m_trdy_n && lat < 0) lat = cyc - cyc0;
            if (!irdy_n && !m_trdy_n) begin
                beat++;
                waited = 0;
                if (frame_n) fin = 1;
                else if (!m_stop_n) begin disc = 1; fin = 1; end
            end
            guard++;
            if (!fin && guard >= (hit ? 60 : 5)) begin
                if (hit) check("txn_timeout", 64'(guard), 64'(0));
                abort = 1;
                fin   = 1;
            end
            tick();
        end
        if (disc || (abort && !frame_n)) begin
            frame_n = 1'b1;
            irdy_n  = 1'b0;
            tick();
        end
        if (abort) begin
            frame_n = 1'b1;
            irdy_n  = 1'b1;
            tick();
        end

        check("beat_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check("strobe", {25'b0, obs_q[i]}, {25'b0, exp_q[i]});
        if (hit) check("first_trdy_latency", 64'(lat), 64'(waits + 1));
        else     check("miss_devsel", 64'(saw_devsel), 64'(0));
    endtask

    vec_t tbl[21];

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra;
        int          rn, rg, pick;

        // cycle-by-cycle vectors for the WAIT_STATES=0 target
        tbl[0]  = mk(0, 1, 32'h1000, 4'h7, 5'b11100, 32'h0000, 4'h0);
        tbl[1]  = mk(1, 0, 32'h0,    4'h0, 5'b00101, 32'h1000, 4'hF);
        tbl[2]  = mk(1, 1, 32'h0,    4'hF, 5'b11100, 32'h1004, 4'h0);
        tbl[3]  = mk(1, 1, 32'h0,    4'hF, 5'b11100, 32'h1004, 4'h0);
        tbl[4]  = mk(0, 1, 32'h2000, 4'h6, 5'b11100, 32'h1004, 4'h0);
        tbl[5]  = mk(0, 0, 32'h2000, 4'h0, 5'b11100, 32'h1004, 4'h0);
        tbl[6]  = mk(1, 0, 32'h0,    4'h0, 5'b11100, 32'h1004, 4'h0);
        tbl[7]  = mk(1, 1, 32'h0,    4'hF, 5'b11100, 32'h1004, 4'h0);
        tbl[8]  = mk(0, 1, 32'h1000, 4'h2, 5'b11100, 32'h1004, 4'h0);
        tbl[9]  = mk(1, 0, 32'h0,    4'h0, 5'b11100, 32'h1004, 4'h0);
        tbl[10] = mk(1, 1, 32'h0,    4'hF, 5'b11100, 32'h1004, 4'h0);
        tbl[11] = mk(1, 1, 32'h0,    4'hF, 5'b11100, 32'h1004, 4'h0);
        tbl[12] = mk(0, 1, 32'h1040, 4'h6, 5'b11100, 32'h1004, 4'h0);
        tbl[13] = mk(1, 0, 32'h0,    4'hC, 5'b01100, 32'h1040, 4'h0);
        tbl[14] = mk(1, 0, 32'h0,    4'hC, 5'b00110, 32'h1040, 4'h3);
        tbl[15] = mk(0, 1, 32'h10FC, 4'h7, 5'b11100, 32'h1044, 4'h0);
        tbl[16] = mk(0, 0, 32'h0,    4'h0, 5'b00001, 32'h10FC, 4'hF);
        tbl[17] = mk(0, 1, 32'h0,    4'h0, 5'b01000, 32'h10FC, 4'h0);
        tbl[18] = mk(1, 0, 32'h0,    4'h0, 5'b01000, 32'h10FC, 4'h0);
        tbl[19] = mk(1, 1, 32'h0,    4'hF, 5'b11100, 32'h10FC, 4'h0);
        tbl[20] = mk(1, 1, 32'h0,    4'hF, 5'b11100, 32'h10FC, 4'h0);

        sel = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        @(negedge clk);
        check("reset_w0", {devsel_n0, trdy_n0, stop_n0, re0, we0, addr0, be0},
              {5'b11100, 32'h0, 4'h0});
        check("reset_w3", {devsel_n3, trdy_n3, stop_n3, re3, we3, addr3, be3},
              {5'b11100, 32'h0, 4'h0});
        tick();

        for (int v = 0; v < 21; v++) begin
            frame_n = tbl[v].f;
            irdy_n  = tbl[v].i;
            ad_in   = tbl[v].ad;
            cbe_n   = tbl[v].cbe;
            @(negedge clk);
            check($sformatf("vec%0d", v),
                  {devsel_n0, trdy_n0, stop_n0, re0, we0, addr0, be0},
                  {tbl[v].ctl, tbl[v].adr, tbl[v].be});
            tick();
        end

        // directed bursts: master wait, beat limit, window end
        do_reset();
        run_txn(4'h6, 32'h1004, 3, 32'b010);
        run_txn(4'h7, 32'h1000, 12, 32'h0);
        run_txn(4'h7, 32'h10F8, 4, 32'h0);
        run_txn(4'h6, 32'h2000, 1, 32'h0);
        run_txn(4'h2, 32'h1000, 1, 32'h0);

        // reset in the middle of a write burst
        do_reset();
        frame_n = 1'b0; irdy_n = 1'b1; ad_in = 32'h1000; cbe_n = 4'h7;
        tick();
        irdy_n = 1'b0; cbe_n = 4'h0;
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_burst_addr", 64'(addr0), 64'(32'h1008));
        tick();
        rst_n = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF;
        @(negedge clk);
        check("reset_mid_burst", {devsel_n0, trdy_n0, stop_n0, re0, we0, addr0, be0},
              {5'b11100, 32'h0, 4'h0});
        tick();
        obs_q.delete();

        // abandoned read during its turnaround wait
        frame_n = 1'b0; irdy_n = 1'b1; ad_in = 32'h1020; cbe_n = 4'h6;
        tick();
        frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF;
        @(negedge clk);
        check("abandon_in_wait", 64'(devsel_n0), 64'(0));
        tick();
        @(negedge clk);
        check("abandon_released", {59'b0, devsel_n0, trdy_n0, stop_n0, re0, we0},
              {59'b0, 5'b11100});
        check("abandon_no_strobe", 64'(obs_q.size()), 64'(0));
        tick();

        // random traffic against both wait-state configurations
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            do_reset();
            if (sel) run_txn(4'h7, 32'h1010, 2, 32'h0);
            for (int t = 0; t < 40; t++) begin
                pick = $urandom_range(0, 99);
                rc = (pick < 45) ? 4'h6 : (pick < 90) ? 4'h7 : 4'($urandom);
                pick = $urandom_range(0, 99);
                if (pick < 70)      ra = 32'h1000 + $urandom_range(0, 255);
                else if (pick < 85) ra = 32'h10E0 + $urandom_range(0, 31);
                else                ra = 32'h0F00 + $urandom_range(0, 32'h2FF);
                rn = $urandom_range(1, 12);
                run_txn(rc, ra, rn, $urandom & $urandom & 32'hFFF);
                rg = $urandom_range(0, 2);
                frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF;
                repeat (rg) tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
